// File: rtl/credit_issuer.sv
// -----------------------------------------------------------------------------
// credit_issuer
//
// Receive-side partner of a link's transmit credit counter. Arriving flits are
// buffered in a DEPTH-entry circular FIFO that feeds the router input, and the
// block hands absolute credit grants back to the link partner. A grant is only
// offered once every previously granted credit has been consumed. At that
// moment nothing is in flight, so overwriting the partner's counter with the
// current free-slot count is exact.
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   rx_valid      a flit arrives this cycle (no backpressure possible)
//   rx_flit       the arriving flit
//   out_valid     FIFO head is valid toward the router
//   out_flit      FIFO head flit
//   out_ready     router takes the head this cycle
//   credit_out    absolute credit grant (free slots, zero-extended)
//   credit_valid  a grant is pending
//   credit_ready  link transmitter takes the grant this cycle
//   overflow      sticky: flit lost because the FIFO was full with no pop
//   proto_err     sticky: flit arrived while no credit was outstanding
// -----------------------------------------------------------------------------
module credit_issuer #(
  parameter int DEPTH        = 8,
  parameter int FLIT_W       = 32,
  parameter int CREDIT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [FLIT_W-1:0]       rx_flit,
  output logic                    out_valid,
  output logic [FLIT_W-1:0]       out_flit,
  input  logic                    out_ready,
  output logic [CREDIT_WIDTH-1:0] credit_out,
  output logic                    credit_valid,
  input  logic                    credit_ready,
  output logic                    overflow,
  output logic                    proto_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  typedef enum logic {
    S_WAIT,
    S_PEND
  } state_t;

  logic [FLIT_W-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CREDIT_WIDTH-1:0] outstanding_q, outstanding_d;
  logic                    overflow_q, overflow_d;
  logic                    protoErr_q, protoErr_d;
  state_t                  state_q, state_d;

  logic                    doPush;
  logic                    doPop;
  logic                    doGrant;
  logic                    doStore;
  logic                    fifoFull;
  logic [CNT_W-1:0]        freeSlots;
  logic [CREDIT_WIDTH-1:0] freeCredit;

  // Pointer advance with wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode. A push into a full FIFO is still stored when the head
  // leaves in the same cycle, because the slot it vacates is reused.
  always_comb begin
    fifoFull   = (count_q == DEPTH_C);
    freeSlots  = DEPTH_C - count_q;
    freeCredit = CREDIT_WIDTH'(freeSlots);
    doPush     = rx_valid;
    doPop      = out_valid & out_ready;
    doGrant    = credit_valid & credit_ready;
    doStore    = doPush & (!fifoFull | doPop);
  end

  // FIFO bookkeeping and sticky error flags.
  always_comb begin
    rdPtr_d    = doPop   ? ptrInc(rdPtr_q) : rdPtr_q;
    wrPtr_d    = doStore ? ptrInc(wrPtr_q) : wrPtr_q;
    count_d    = count_q + CNT_W'(doStore) - CNT_W'(doPop);
    overflow_d = overflow_q | (doPush & fifoFull & !doPop);
    protoErr_d = protoErr_q | (doPush & (outstanding_q == '0));
  end

  // Outstanding credit tracking. A grant overwrites the partner's counter, so
  // the local copy restarts from the granted value, less any flit arriving in
  // the same cycle. Saturation guards the degenerate zero-credit grant that
  // can only follow illegal pushes.
  always_comb begin
    outstanding_d = outstanding_q;
    if (doGrant) begin
      if (freeCredit == '0) begin
        outstanding_d = '0;
      end else begin
        outstanding_d = freeCredit - CREDIT_WIDTH'(doPush);
      end
    end else if (doPush && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - CREDIT_WIDTH'(1);
    end
  end

  // Credit FSM next state: arm only when every granted credit is used up and
  // there is at least one slot to offer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if ((outstanding_q == '0) && (freeSlots != '0)) begin
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (credit_ready) begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_PEND;
    endcase
  end

  // Credit FSM outputs. The offered value tracks free slots live, so it can
  // only grow while pending as the router drains entries.
  always_comb begin
    credit_valid = (state_q == S_PEND);
    credit_out   = (state_q == S_PEND) ? freeCredit : '0;
  end

  // FIFO head and flag outputs.
  always_comb begin
    out_valid = (count_q != '0);
    out_flit  = mem_q[rdPtr_q];
    overflow  = overflow_q;
    proto_err = protoErr_q;
  end

  // Control state register. Reset leaves a full-depth grant pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
      protoErr_q    <= 1'b0;
      state_q       <= S_PEND;
    end else begin
      rdPtr_q       <= rdPtr_d;
      wrPtr_q       <= wrPtr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      overflow_q    <= overflow_d;
      protoErr_q    <= protoErr_d;
      state_q       <= state_d;
    end
  end

  // Flit storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (doStore) begin
      mem_q[wrPtr_q] <= rx_flit;
    end
  end

endmodule
